banked_scalar_reg_file: RTL



---
 rtl/banked_scalar_reg_file_pkg.sv | 34 +++
 rtl/banked_scalar_reg_file_if.sv | 22 ++
 rtl/scalar_scoreboard.sv | 53 +++++
 rtl/banked_scalar_reg_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/banked_scalar_reg_file_pkg.sv
// Shared types for the banked scalar register file and its neighbours.
package banked_scalar_reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_WARPS  = 4;
  localparam int unsigned DEFAULT_NUM_REGS   = 32;
  localparam int unsigned INSTR_ADDR_WIDTH   = 12;

  typedef logic [DEFAULT_DATA_WIDTH-1:0]         data_t;
  typedef logic [INSTR_ADDR_WIDTH-1:0]           instruction_memory_address_t;
  typedef logic [$clog2(DEFAULT_NUM_WARPS)-1:0]  warp_id_t;
  typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0]   reg_addr_t;

  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;

  typedef enum logic [1:0] {
    WARP_IDLE  = 2'd0,
    WARP_READY = 2'd1,
    WARP_WAIT  = 2'd2,
    WARP_DONE  = 2'd3
  } warp_state_t;

  // Next sequential PC; wraps at the instruction-address width.
  function automatic instruction_memory_address_t pc_plus_one(input instruction_memory_address_t pc);
    return pc + INSTR_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/banked_scalar_reg_file_if.sv
// Handshaked LSU load-return channel into the scalar register file.
interface banked_scalar_reg_file_if #(
  parameter int unsigned NUM_WARPS  = 4,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                         lsu_wb_valid;
  logic                         lsu_wb_ready;
  logic [$clog2(NUM_WARPS)-1:0] lsu_wb_warp_id;
  logic [$clog2(NUM_REGS)-1:0]  lsu_wb_rd;
  logic [DATA_WIDTH-1:0]        lsu_wb_data;

  modport master (
    output lsu_wb_valid, lsu_wb_warp_id, lsu_wb_rd, lsu_wb_data,
    input  lsu_wb_ready
  );

  modport slave (
    input  lsu_wb_valid, lsu_wb_warp_id, lsu_wb_rd, lsu_wb_data,
    output lsu_wb_ready
  );
endinterface

// File: rtl/scalar_scoreboard.sv
// Per-warp, per-register pending bits for outstanding LSU loads.
module scalar_scoreboard #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [$clog2(NUM_WARPS)-1:0] init_id,
  input  logic                         set_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] set_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]  set_rd,
  input  logic                         clr_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] clr_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]  clr_rd,
  input  logic [$clog2(NUM_WARPS)-1:0] rd_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]  rs1_address,
  input  logic [$clog2(NUM_REGS)-1:0]  rs2_address,
  input  logic [$clog2(NUM_WARPS)-1:0] chk_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]  chk_rd,
  output logic                         rs1_pending,
  output logic                         rs2_pending,
  output logic                         chk_pending
);
  localparam int unsigned WW = $clog2(NUM_WARPS);

  logic [NUM_REGS-1:0] pending [NUM_WARPS];

  // Clear on load return, then set on issue (a new load outranks the old
  // return), then bank re-init overrides both.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        pending[WW'(w)] <= '0;
      end
    end else begin
      if (clr_valid) begin
        pending[clr_warp_id][clr_rd] <= 1'b0;
      end
      if (set_valid && (set_rd != '0)) begin
        pending[set_warp_id][set_rd] <= 1'b1;
      end
      if (init) begin
        pending[init_id] <= '0;
      end
    end
  end

  assign rs1_pending = !reset && (rs1_address != '0) && pending[rd_warp_id][rs1_address];
  assign rs2_pending = !reset && (rs2_address != '0) && pending[rd_warp_id][rs2_address];
  assign chk_pending = pending[chk_warp_id][chk_rd];

endmodule

// File: rtl/banked_scalar_reg_file.sv
// Multi-warp scalar register file: one bank per warp, bypassed reads,
// WARP_UPDATE write-back plus a handshaked LSU return port and load scoreboard.
module banked_scalar_reg_file
  import banked_scalar_reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_WARPS     = DEFAULT_NUM_WARPS,
  parameter int unsigned NUM_REGS      = DEFAULT_NUM_REGS,
  parameter int unsigned EXEC_MASK_REG = 31
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            warp_init,
  input  logic [$clog2(NUM_WARPS)-1:0]    warp_init_id,
  input  logic [$clog2(NUM_WARPS)-1:0]    rd_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]     rs1_address,
  input  logic [$clog2(NUM_REGS)-1:0]     rs2_address,
  output logic [DATA_WIDTH-1:0]           rs1,
  output logic [DATA_WIDTH-1:0]           rs2,
  output logic                            rs1_pending,
  output logic                            rs2_pending,
  input  logic                            wb_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]    wb_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]     wb_rd_address,
  input  reg_input_mux_t                  wb_input_mux,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  input  logic [DATA_WIDTH-1:0]           lsu_out,
  input  logic [DATA_WIDTH-1:0]           immediate,
  input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
  input  instruction_memory_address_t     pc,
  input  logic                            load_issue_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]    load_issue_warp_id,
  input  logic [$clog2(NUM_REGS)-1:0]     load_issue_rd,
  banked_scalar_reg_file_if.slave         lsu_wb,
  output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_mask
);
  localparam int unsigned WW = $clog2(NUM_WARPS);
  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0] MASK_IDX = RW'(EXEC_MASK_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_WARPS][NUM_REGS];

  instruction_memory_address_t pc_next;
  logic [DATA_WIDTH-1:0]       wb_value;
  logic                        wb_mux_ok;
  logic                        wb_bank_init;
  logic                        lsu_bank_init;
  logic                        lsu_fire;
  logic                        wb_we;
  logic                        lsu_we;
  logic                        wb_pending;
  logic [RW-1:0]               rd_addr [2];
  logic [DATA_WIDTH-1:0]       rd_data [2];

  function automatic logic [DATA_WIDTH-1:0] init_value(input logic [RW-1:0] idx);
    if ((idx == RW'(1)) || (idx == MASK_IDX)) begin
      return {DATA_WIDTH{1'b1}};
    end
    return {DATA_WIDTH{1'b0}};
  endfunction

  assign pc_next = pc_plus_one(pc);

  // Write-back source select; unknown encodings flag and suppress the write.
  always_comb begin
    wb_value  = '0;
    wb_mux_ok = 1'b1;
    case (wb_input_mux)
      ALU_OUT:          wb_value = alu_out;
      LSU_OUT:          wb_value = lsu_out;
      IMMEDIATE:        wb_value = immediate;
      PC_PLUS_1:        wb_value = DATA_WIDTH'(pc_next);
      VECTOR_TO_SCALAR: wb_value = vector_to_scalar_data;
      default:          wb_mux_ok = 1'b0;
    endcase
  end

  assign lsu_wb.lsu_wb_ready = !reset && !wb_valid;
  assign lsu_fire      = lsu_wb.lsu_wb_valid && lsu_wb.lsu_wb_ready;
  assign wb_bank_init  = warp_init && (warp_init_id == wb_warp_id);
  assign lsu_bank_init = warp_init && (warp_init_id == lsu_wb.lsu_wb_warp_id);
  assign wb_we  = !reset && wb_valid && wb_mux_ok && (wb_rd_address != '0) && !wb_bank_init;
  assign lsu_we = lsu_fire && (lsu_wb.lsu_wb_rd != '0) && !lsu_bank_init;

  scalar_scoreboard #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .init        (warp_init),
    .init_id     (warp_init_id),
    .set_valid   (load_issue_valid),
    .set_warp_id (load_issue_warp_id),
    .set_rd      (load_issue_rd),
    .clr_valid   (lsu_fire),
    .clr_warp_id (lsu_wb.lsu_wb_warp_id),
    .clr_rd      (lsu_wb.lsu_wb_rd),
    .rd_warp_id  (rd_warp_id),
    .rs1_address (rs1_address),
    .rs2_address (rs2_address),
    .chk_warp_id (wb_warp_id),
    .chk_rd      (wb_rd_address),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .chk_pending (wb_pending)
  );

  // Bank storage: reset/init load the launch values; init beats same-bank writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          regs[WW'(w)][RW'(r)] <= init_value(RW'(r));
        end
      end
    end else begin
      if (wb_we) begin
        regs[wb_warp_id][wb_rd_address] <= wb_value;
      end
      if (lsu_we) begin
        regs[lsu_wb.lsu_wb_warp_id][lsu_wb.lsu_wb_rd] <= lsu_wb.lsu_wb_data;
      end
      if (warp_init) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          regs[warp_init_id][RW'(r)] <= init_value(RW'(r));
        end
      end
      assert (!wb_valid || wb_mux_ok)
        else $error("banked_scalar_reg_file: invalid wb_input_mux %0d", wb_input_mux);
      assert (!(wb_valid && (wb_rd_address != '0) && wb_pending && !wb_bank_init))
        else $error("banked_scalar_reg_file: WAW on pending warp %0d r%0d", wb_warp_id, wb_rd_address);
    end
  end

  assign rd_addr[0] = rs1_address;
  assign rd_addr[1] = rs2_address;

  // Read ports: same-cycle init, write-back and LSU commits are forwarded.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_warp_id][rd_addr[p]];
      if (warp_init && (warp_init_id == rd_warp_id)) begin
        rd_data[p] = init_value(rd_addr[p]);
      end else if (wb_we && (wb_warp_id == rd_warp_id) && (wb_rd_address == rd_addr[p])) begin
        rd_data[p] = wb_value;
      end else if (lsu_we && (lsu_wb.lsu_wb_warp_id == rd_warp_id) && (lsu_wb.lsu_wb_rd == rd_addr[p])) begin
        rd_data[p] = lsu_wb.lsu_wb_data;
      end
      if (reset || (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end
    end
  end

  assign rs1 = rd_data[0];
  assign rs2 = rd_data[1];

  // Execution masks come straight from the array, so writes show next cycle.
  always_comb begin
    warp_execution_mask = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      warp_execution_mask[w*DATA_WIDTH +: DATA_WIDTH] = regs[WW'(w)][MASK_IDX];
    end
  end

endmodule
